// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive frame controller: FSM encoding,
// default sample width and frame-width helper.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_WAIT_L = 2'd3
  } state_e;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_FRAME_W = 2 * DEF_DATA_W;

  function automatic int frame_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// First-word-fall-through synchronous FIFO for stereo frames.
// Pointers carry one extra wrap bit so full/empty need no special casing.
module i2s_frame_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = DEF_FRAME_W,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  assign data_o = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_mem[gi] <= '0;
        end else if (w_do_push && (r_wr_ptr[AW-1:0] == AW'(gi))) begin
          r_mem[gi] <= data_i;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/i2s_rx_frame_ctrl.sv
// Pairs I2S left/right sample strobes into stereo frames and buffers them
// for a valid/ready consumer. Optional I2S_RX_FRAME_CTRL_DESYNC_CNT_EN adds desync_cnt_o.
module i2s_rx_frame_ctrl
  import i2s_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  lr_chnl_i,
  input  logic                  write_i,
  output logic [2*DATA_W-1:0]   frame_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overflow_o,
  output logic [CNT_W-1:0]      ovf_cnt_o,
`ifdef I2S_RX_FRAME_CTRL_DESYNC_CNT_EN
  output logic [CNT_W-1:0]      desync_cnt_o,
`endif
  input  logic                  clr_i,
  output logic [1:0]            state_o
);

  localparam int FRAME_W = frame_w(DATA_W);

  state_e              r_state;
  state_e              w_state_next;
  logic [DATA_W-1:0]   r_left_hold;
  logic                w_load_left;
  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic                w_drop;
  logic                r_overflow;
  logic [CNT_W-1:0]    r_ovf_cnt;
  logic [FRAME_W-1:0]  w_frame_in;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load_left  = 1'b0;
    w_push       = 1'b0;
    if (!en_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = ST_SYNC;
        ST_SYNC: begin
          if (write_i && !lr_chnl_i) begin
            w_load_left  = 1'b1;
            w_state_next = ST_WAIT_R;
          end
        end
        ST_WAIT_R: begin
          if (write_i && lr_chnl_i) begin
            w_push       = 1'b1;
            w_state_next = ST_WAIT_L;
          end else if (write_i) begin
            w_load_left  = 1'b1;
          end
        end
        ST_WAIT_L: begin
          if (write_i && !lr_chnl_i) begin
            w_load_left  = 1'b1;
            w_state_next = ST_WAIT_R;
          end else if (write_i) begin
            w_state_next = ST_SYNC;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          r_left_hold <= '0;
    else if (w_load_left) r_left_hold <= data_i;
  end

  assign w_frame_in = {data_i, r_left_hold};

  i2s_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_frame_in),
    .pop_i   (ready_i),
    .data_o  (frame_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Full implies non-empty, so a ready consumer always makes room this cycle.
  assign w_drop = w_push && w_full && !ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow <= 1'b0;
      r_ovf_cnt  <= '0;
    end else if (clr_i) begin
      r_overflow <= 1'b0;
      r_ovf_cnt  <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

`ifdef I2S_RX_FRAME_CTRL_DESYNC_CNT_EN
  logic             w_desync;
  logic [CNT_W-1:0] r_desync_cnt;

  assign w_desync = en_i && write_i &&
                    (((r_state == ST_WAIT_R) && !lr_chnl_i) ||
                     ((r_state == ST_WAIT_L) &&  lr_chnl_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_desync_cnt <= '0;
    end else if (clr_i) begin
      r_desync_cnt <= '0;
    end else if (w_desync && (r_desync_cnt != '1)) begin
      r_desync_cnt <= r_desync_cnt + 1'b1;
    end
  end

  assign desync_cnt_o = r_desync_cnt;
`endif

  assign valid_o    = !w_empty;
  assign overflow_o = r_overflow;
  assign ovf_cnt_o  = r_ovf_cnt;
  assign state_o    = r_state;

endmodule

// File: tb/tb_i2s_rx_frame_ctrl.sv
// Directed bench for i2s_rx_frame_ctrl: framing, desync, overflow, clear,
// enable gating and async reset. Honours I2S_RX_FRAME_CTRL_DESYNC_CNT_EN.
module tb_i2s_rx_frame_ctrl;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                en_i;
  logic [DATA_W-1:0]   data_i;
  logic                lr_chnl_i;
  logic                write_i;
  logic [2*DATA_W-1:0] frame_o;
  logic                valid_o;
  logic                ready_i;
  logic                overflow_o;
  logic [CNT_W-1:0]    ovf_cnt_o;
  logic                clr_i;
  logic [1:0]          state_o;
`ifdef I2S_RX_FRAME_CTRL_DESYNC_CNT_EN
  logic [CNT_W-1:0]    desync_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  i2s_rx_frame_ctrl #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .data_i       (data_i),
    .lr_chnl_i    (lr_chnl_i),
    .write_i      (write_i),
    .frame_o      (frame_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .overflow_o   (overflow_o),
    .ovf_cnt_o    (ovf_cnt_o),
`ifdef I2S_RX_FRAME_CTRL_DESYNC_CNT_EN
    .desync_cnt_o (desync_cnt_o),
`endif
    .clr_i        (clr_i),
    .state_o      (state_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic strobe(input logic lr, input logic [DATA_W-1:0] d);
    @(negedge clk_i);
    write_i   = 1'b1;
    lr_chnl_i = lr;
    data_i    = d;
    @(negedge clk_i);
    write_i   = 1'b0;
  endtask

  logic [31:0] exp_q [4];

  initial begin
    rst_ni = 1'b0; en_i = 1'b0; data_i = '0; lr_chnl_i = 1'b0;
    write_i = 1'b0; ready_i = 1'b0; clr_i = 1'b0;
    repeat (2) tick();
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_frame", 64'(frame_o), 64'd0);
    chk("rst_ovf",   64'(overflow_o), 64'd0);
    chk("rst_ovfcnt", 64'(ovf_cnt_o), 64'd0);
    rst_ni = 1'b1;
    tick();
    chk("idle_no_en", 64'(state_o), 64'd0);
    en_i = 1'b1;
    tick();
    chk("en_sync", 64'(state_o), 64'd1);

    // Basic frame
    ready_i = 1'b1;
    strobe(1'b0, 16'hA5A5);
    chk("after_l_state", 64'(state_o), 64'd2);
    strobe(1'b1, 16'h5A5A);
    chk("t1_valid", 64'(valid_o), 64'd1);
    chk("t1_frame", 64'(frame_o), 64'h5A5A_A5A5);
    chk("t1_state", 64'(state_o), 64'd3);
    tick();
    chk("t1_popped", 64'(valid_o), 64'd0);

    // Mid-frame start
    en_i = 1'b0; ready_i = 1'b0;
    tick();
    chk("t2_idle", 64'(state_o), 64'd0);
    en_i = 1'b1;
    tick();
    strobe(1'b1, 16'h1111);
    chk("t2_r_discard", 64'(valid_o), 64'd0);
    strobe(1'b0, 16'h2222);
    strobe(1'b1, 16'h3333);
    chk("t2_valid", 64'(valid_o), 64'd1);
    chk("t2_frame", 64'(frame_o), 64'h3333_2222);
    ready_i = 1'b1;
    tick();
    chk("t2_one_frame", 64'(valid_o), 64'd0);
    ready_i = 1'b0;

    // Fill to full, fifth frame dropped
    for (int k = 1; k <= 5; k++) begin
      strobe(1'b0, 16'h1000 + 16'(k));
      strobe(1'b1, 16'h2000 + 16'(k));
      if (k == 4) chk("t3_no_ovf_yet", 64'(overflow_o), 64'd0);
    end
    chk("t3_ovf", 64'(overflow_o), 64'd1);
    chk("t3_ovfcnt", 64'(ovf_cnt_o), 64'd1);
    chk("t3_head", 64'(frame_o), 64'h2001_1001);

    // Full with simultaneous pop: no drop
    strobe(1'b0, 16'h1006);
    @(negedge clk_i);
    write_i = 1'b1; lr_chnl_i = 1'b1; data_i = 16'h2006; ready_i = 1'b1;
    @(negedge clk_i);
    write_i = 1'b0; ready_i = 1'b0;
    chk("t4_ovfcnt_same", 64'(ovf_cnt_o), 64'd1);
    exp_q[0] = 32'h2002_1002; exp_q[1] = 32'h2003_1003;
    exp_q[2] = 32'h2004_1004; exp_q[3] = 32'h2006_1006;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_valid", 64'(valid_o), 64'd1);
      chk("t4_drain", 64'(frame_o), 64'(exp_q[i]));
      tick();
    end
    chk("t4_empty", 64'(valid_o), 64'd0);
    ready_i = 1'b0;

    // Clear coincident with a drop: clear wins
    for (int k = 7; k <= 10; k++) begin
      strobe(1'b0, 16'h1000 + 16'(k));
      strobe(1'b1, 16'h2000 + 16'(k));
    end
    strobe(1'b0, 16'h100B);
    @(negedge clk_i);
    write_i = 1'b1; lr_chnl_i = 1'b1; data_i = 16'h200B; clr_i = 1'b1;
    @(negedge clk_i);
    write_i = 1'b0; clr_i = 1'b0;
    chk("clr_ovf", 64'(overflow_o), 64'd0);
    chk("clr_ovfcnt", 64'(ovf_cnt_o), 64'd0);
    chk("clr_head", 64'(frame_o), 64'h2007_1007);
    ready_i = 1'b1;
    repeat (4) tick();
    chk("clr_drained", 64'(valid_o), 64'd0);
    ready_i = 1'b0;

    // Desync: repeated L, then R in WAIT_L
    strobe(1'b0, 16'h0001);
    strobe(1'b0, 16'h0002);
    chk("ds_state_wr", 64'(state_o), 64'd2);
    strobe(1'b1, 16'h0003);
    chk("ds_valid", 64'(valid_o), 64'd1);
    chk("ds_frame", 64'(frame_o), 64'h0003_0002);
`ifdef I2S_RX_FRAME_CTRL_DESYNC_CNT_EN
    chk("ds_cnt1", 64'(desync_cnt_o), 64'd1);
`endif
    strobe(1'b1, 16'h00EE);
    chk("ds_to_sync", 64'(state_o), 64'd1);
`ifdef I2S_RX_FRAME_CTRL_DESYNC_CNT_EN
    chk("ds_cnt2", 64'(desync_cnt_o), 64'd2);
`endif
    ready_i = 1'b1;
    tick();
    chk("ds_drained", 64'(valid_o), 64'd0);
    ready_i = 1'b0;

    // Enable dropped mid-frame
    strobe(1'b0, 16'h00AA);
    chk("en_wr", 64'(state_o), 64'd2);
    en_i = 1'b0;
    tick();
    chk("en_off_idle", 64'(state_o), 64'd0);
    en_i = 1'b1;
    tick();
    strobe(1'b1, 16'h00BB);
    chk("en_no_push", 64'(valid_o), 64'd0);
    chk("en_sync_again", 64'(state_o), 64'd1);

    // Async reset mid-frame
    strobe(1'b0, 16'h0C0C);
    strobe(1'b1, 16'h0D0D);
    strobe(1'b0, 16'h0E0E);
    chk("pre_rst_valid", 64'(valid_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_state", 64'(state_o), 64'd0);
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_frame", 64'(frame_o), 64'd0);
    chk("arst_ovf", 64'(overflow_o), 64'd0);
    chk("arst_ovfcnt", 64'(ovf_cnt_o), 64'd0);
`ifdef I2S_RX_FRAME_CTRL_DESYNC_CNT_EN
    chk("arst_dscnt", 64'(desync_cnt_o), 64'd0);
`endif
    tick();
    rst_ni = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
